pdp8_tt_txarb: RTL and testbench

//  Round-robin arbiter sharing one console UART transmitter among NREQ teletype

---
 rtl/pdp8_tt_txarb.sv | 106 ++++++++++
 tb/tb_pdp8_tt_txarb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pdp8_tt_txarb.sv
// pdp8_tt_txarb: round-robin arbiter sharing one UART transmitter among NREQ tt output channels
module pdp8_tt_txarb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   chan_req,
   input  logic [8*NREQ-1:0] chan_data,
   output logic [NREQ-1:0]   chan_ack,
   output logic [NREQ-1:0]   chan_done,
   output logic [NREQ-1:0]   chan_err,
   output logic              tx_req,
   input  logic              tx_ack,
   output logic [7:0]        tx_data,
   input  logic              tx_empty,
   output logic              busy,
   output logic [2:0]        grant_id
);
   localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WLIM = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   typedef enum logic [1:0] {IDLE, REQ, WACK, WEMPTY} state_t;
   state_t state_q, state_d;
   logic [2:0] ptr_q, ptr_d, grant_id_q, grant_id_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic [NREQ-1:0] ack_q, ack_d, done_q, done_d, err_q, err_d, sh;
   logic hit;
   int win;
   // scan downward so the channel nearest after ptr overrides the rest
   always_comb begin
      win = 0;
      hit = 1'b0;
      sh = '0;
      for (int i = NREQ; i >= 1; i--) begin
         sh = chan_req >> ((int'(ptr_q) + i) % NREQ);
         if (sh[0]) begin
            hit = 1'b1;
            win = (int'(ptr_q) + i) % NREQ;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      grant_id_d = grant_id_q;
      tx_data_d = tx_data_q;
      wdog_d = wdog_q + 1'b1;
      ack_d = '0;
      done_d = '0;
      err_d = '0;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (hit) begin
               state_d = REQ;
               ptr_d = 3'(win);
               grant_id_d = 3'(win);
               tx_data_d = 8'(chan_data >> (8 * win));
               ack_d = NREQ'(1) << win;
            end
         end
         REQ: state_d = tx_ack ? WACK : REQ;
         WACK: state_d = tx_ack ? WACK : WEMPTY;
         default: if (tx_empty) begin
            state_d = IDLE;
            done_d = NREQ'(1) << grant_id_q;
         end
      endcase
      // a real handshake transition takes priority over the watchdog
      if (state_d != state_q) wdog_d = '0;
      else if (state_q != IDLE && TIMEOUT != 0 && wdog_q == WLIM) begin
         state_d = IDLE;
         wdog_d = '0;
         err_d = NREQ'(1) << grant_id_q;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q <= 3'(NREQ - 1);
         grant_id_q <= '0;
         tx_data_q <= '0;
         wdog_q <= '0;
         ack_q <= '0;
         done_q <= '0;
         err_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         grant_id_q <= grant_id_d;
         tx_data_q <= tx_data_d;
         wdog_q <= wdog_d;
         ack_q <= ack_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
   assign chan_ack = ack_q;
   assign chan_done = done_q;
   assign chan_err = err_q;
   assign tx_req = state_q == REQ;
   assign busy = state_q != IDLE;
   assign tx_data = tx_data_q;
   assign grant_id = grant_id_q;
endmodule

// File: tb/tb_pdp8_tt_txarb.sv
// tb_pdp8_tt_txarb: randomized bench with a transaction-timeline reference model
module tb_pdp8_tt_txarb;
   localparam int NREQ = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic [3:0] chan_req = '0, chan_ack, chan_done, chan_err;
   logic [31:0] chan_data = '0;
   logic tx_req, tx_ack = 1'b0, tx_empty = 1'b1, busy;
   logic [7:0] tx_data;
   logic [2:0] grant_id;
   always #5 clk = ~clk;
   pdp8_tt_txarb #(.NREQ(NREQ), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .chan_req(chan_req), .chan_data(chan_data),
      .chan_ack(chan_ack), .chan_done(chan_done), .chan_err(chan_err),
      .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data), .tx_empty(tx_empty),
      .busy(busy), .grant_id(grant_id)
   );
   int n_chk = 0, n_fail = 0;
   int k, c0, end_c, da, h, e, ptr, g, pg, mode;
   int fda = -1, fh = -1, fe = -1;
   bit to;
   logic [7:0] d, pd;
   logic [3:0] req_v = '0;
   int gq[$], doneq[$], errq[$];
   logic [7:0] dq[$];
   int exp3[6] = '{0, 1, 2, 3, 0, 1};
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int oh(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction
   task automatic model_reset;
      c0 = -1000; end_c = -999; ptr = NREQ - 1;
      g = 0; pg = 0; d = '0; pd = '0; da = 0; h = 1; e = 0; to = 0;
   endtask
   task automatic clear_logs;
      gq.delete(); dq.delete(); doneq.delete(); errq.delete();
   endtask
   // each transaction is a timeline: grant at c0, ack at c0+da, end at end_c
   task automatic cycle_check;
      logic [3:0] one;
      bit act;
      act = k >= c0 && k < end_c;
      one = 4'(1 << g);
      check("chan_ack", chan_ack, k == c0 ? one : 4'h0);
      check("chan_done", chan_done, (k == end_c && !to) ? one : 4'h0);
      check("chan_err", chan_err, (k == end_c && to) ? one : 4'h0);
      check("busy", busy, act);
      check("tx_req", tx_req, act && k <= c0 + (da >= 16 ? 15 : da));
      check("grant_id", grant_id, k >= c0 ? g : pg);
      check("tx_data", tx_data, k >= c0 ? d : pd);
      if (chan_ack != 0) begin gq.push_back(int'(grant_id)); dq.push_back(tx_data); end
      if (chan_done != 0) doneq.push_back(oh(chan_done));
      if (chan_err != 0) errq.push_back(oh(chan_err));
   endtask
   task automatic drive;
      int w;
      w = -1;
      if (k == c0 && mode != 2) req_v[g] = 1'b0;
      if (mode == 0) begin
         for (int i = 0; i < 4; i++) if (!req_v[i] && $urandom_range(5) == 0) req_v[i] = 1'b1;
         chan_data = $urandom;
      end
      chan_req = req_v;
      if (k >= end_c && req_v != 0) begin
         for (int i = 1; i <= 4; i++) if (w < 0 && req_v[(ptr + i) % 4]) w = (ptr + i) % 4;
         pg = g; pd = d; g = w; d = chan_data[8*w +: 8]; ptr = w; c0 = k + 1;
         da = fda >= 0 ? fda : ($urandom_range(19) == 19 ? 16 + int'($urandom_range(3)) : int'($urandom_range(5)));
         h = fh >= 0 ? fh : 1 + int'($urandom_range(2));
         e = fe >= 0 ? fe : ($urandom_range(19) == 19 ? 16 + int'($urandom_range(2)) : int'($urandom_range(5)));
         to = da >= 16 || e >= 16;
         end_c = da >= 16 ? c0 + 16 : e >= 16 ? c0 + da + h + 17 : c0 + da + h + e + 2;
      end
      tx_ack = da < 16 && k >= c0 + da && k < c0 + da + h;
      tx_empty = (k >= c0 && k < end_c) ? (e < 16 && k >= (e == 0 ? c0 + da + h : c0 + da + h + 1 + e)) : 1'b1;
   endtask
   task automatic step;
      @(negedge clk);
      k++;
      cycle_check();
      drive();
   endtask
   task automatic wait_grants(input int n, input int budget);
      int b;
      b = 0;
      while (gq.size() < n && b < budget) begin step(); b++; end
      check("grant_wait", gq.size() >= n, 1'b1);
   endtask
   task automatic set_t(input int a, input int b, input int c);
      fda = a; fh = b; fe = c;
   endtask
   initial begin
      #1ms;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      mode = 2; k = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_outputs", {chan_ack, chan_done, chan_err, tx_req, busy, grant_id, tx_data}, 0);
      reset = 1'b0;
      cycle_check();
      drive();
      // rotation under permanent full request, pointer starting at 3
      chan_data = 32'h4433_2211; req_v = 4'hf; set_t(1, 1, 1);
      wait_grants(6, 200);
      req_v = 4'h0;
      for (int i = 0; i < 6; i++) begin
         check("t3_order", gq[i], exp3[i]);
         check("t3_data", dq[i], 8'(32'h4433_2211 >> (8 * exp3[i])));
      end
      repeat (30) step();
      clear_logs();
      // single character on channel 0
      mode = 1; chan_data = 32'h0000_0041; req_v = 4'b0001; set_t(3, 1, 12);
      wait_grants(1, 50);
      repeat (40) step();
      check("t1_gid", gq[0], 0);
      check("t1_data", dq[0], 8'o101);
      check("t1_ndone", doneq.size(), 1);
      check("t1_done_id", doneq[0], 0);
      clear_logs();
      // two channels requesting, each dropped on ack
      chan_data = 32'hA5C3_3C5A; req_v = 4'b0110; set_t(2, 2, 3);
      wait_grants(2, 100);
      repeat (30) step();
      check("t2_g0", gq[0], 1);
      check("t2_g1", gq[1], 2);
      check("t2_d0", dq[0], 8'h3C);
      check("t2_d1", dq[1], 8'hC3);
      check("t2_ndone", doneq.size(), 2);
      check("t2_done1", doneq[1], 2);
      clear_logs();
      // ack never arrives: abort, then ack on the last allowed cycle, then empty timeout
      req_v = 4'b1000; set_t(20, 1, 1);
      wait_grants(1, 50);
      repeat (25) step();
      check("t4_nerr", errq.size(), 1);
      check("t4_err_id", errq[0], 3);
      check("t4_nodone", doneq.size(), 0);
      req_v = 4'b0001; set_t(15, 1, 2);
      wait_grants(2, 50);
      repeat (30) step();
      check("t4_edge_done", doneq.size(), 1);
      check("t4_edge_nerr", errq.size(), 1);
      req_v = 4'b0100; set_t(1, 1, 18);
      wait_grants(3, 50);
      repeat (40) step();
      check("t4_empty_err", errq.size(), 2);
      check("t4_empty_id", errq[1], 2);
      // tx_empty already high when tx_ack falls
      req_v = 4'b0010; set_t(1, 2, 0);
      wait_grants(4, 50);
      repeat (15) step();
      check("t6_ndone", doneq.size(), 2);
      check("t6_done_id", doneq[1], 1);
      clear_logs();
      // asynchronous reset while waiting for tx_ack to fall
      req_v = 4'b0001; set_t(2, 3, 2);
      wait_grants(1, 50);
      step(); step(); step();
      #1 reset = 1'b1;
      #1 check("t5_async", {chan_ack, chan_done, chan_err, tx_req, busy, grant_id, tx_data}, 0);
      req_v = 4'hf; mode = 2;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      k++;
      model_reset();
      clear_logs();
      cycle_check();
      drive();
      wait_grants(1, 20);
      check("t5_first", gq[0], 0);
      req_v = 4'h0;
      repeat (40) step();
      clear_logs();
      // random traffic with random uart timing and occasional timeouts
      mode = 0; set_t(-1, -1, -1);
      repeat (3000) step();
      mode = 1; req_v = 4'h0;
      repeat (60) step();
      check("rand_activity", gq.size() > 20, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
